// File: rtl/y86_pipe_ctrl_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings (icodes, status, register IDs) and the
//               run-state type used by the pipeline control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] c_IHALT   = 4'h0;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_IJXX    = 4'h7;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    localparam logic [1:0] c_SAOK = 2'd0;
    localparam logic [1:0] c_SHLT = 2'd1;
    localparam logic [1:0] c_SADR = 2'd2;
    localparam logic [1:0] c_SINS = 2'd3;

    // Register ID meaning "no register" at the native 4-bit width
    localparam logic [3:0] c_RNONE = 4'hF;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/y86_pipe_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/y86_pipe_ctrl.sv
// ============================================================================
// Module      : y86_pipe_ctrl
// Description : Hazard / pipeline-control unit for the five-stage Y86-64 pipe,
//               with run-state tracking and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_pipe_ctrl
    import y86_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 32,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstE,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic [REG_W-1:0]   M_dstE,
    input  logic [REG_W-1:0]   M_dstM,
    input  logic [REG_W-1:0]   W_dstE,
    input  logic [REG_W-1:0]   W_dstM,
    input  logic               e_Cnd,
    input  logic [1:0]         m_stat,
    input  logic [1:0]         W_stat,
    output logic               F_stall,
    output logic               D_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               set_cc,
    output logic               halted,
    output logic [1:0]         cpu_stat,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   mispred_cnt
);

    localparam logic [REG_W-1:0] c_RNONE_W = {REG_W{1'b1}};

    state_t r_state;
    state_t w_nextState;
    logic   [1:0] r_cpuStat;

    logic w_loadUse;
    logic w_rawAny;
    logic w_raw;
    logic w_dataHaz;
    logic w_retHaz;
    logic w_mispred;
    logic w_excM;
    logic w_excW;

    // Run-mode control values, before the halted-state overrides
    logic w_fStallRun;
    logic w_dBubbleRun;
    logic w_eBubbleRun;

    // A real destination matching a source also implies that source is real
    function automatic logic srcHit(input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] srcA,
                                    input logic [REG_W-1:0] srcB);
        return (dst != c_RNONE_W) && ((dst == srcA) || (dst == srcB));
    endfunction

    assign w_excM = (m_stat != c_SAOK);
    assign w_excW = (W_stat != c_SAOK);

    assign w_loadUse = ((E_icode == ICODE_W'(c_IMRMOVQ)) || (E_icode == ICODE_W'(c_IPOPQ)))
                       && srcHit(E_dstM, d_srcA, d_srcB);

    assign w_rawAny = srcHit(E_dstE, d_srcA, d_srcB) || srcHit(E_dstM, d_srcA, d_srcB)
                   || srcHit(M_dstE, d_srcA, d_srcB) || srcHit(M_dstM, d_srcA, d_srcB)
                   || srcHit(W_dstE, d_srcA, d_srcB) || srcHit(W_dstM, d_srcA, d_srcB);
    assign w_raw     = !FWD_EN && w_rawAny;
    assign w_dataHaz = w_loadUse || w_raw;

    assign w_retHaz  = (D_icode == ICODE_W'(c_IRET)) || (E_icode == ICODE_W'(c_IRET))
                    || (M_icode == ICODE_W'(c_IRET));
    assign w_mispred = (E_icode == ICODE_W'(c_IJXX)) && !e_Cnd;

    // D stall wins over D bubble so the stage register never sees both
    assign w_fStallRun  = w_dataHaz || w_retHaz;
    assign w_dBubbleRun = (w_mispred || (w_retHaz && !w_dataHaz)) && !w_dataHaz;
    assign w_eBubbleRun = w_mispred || w_dataHaz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_cpuStat <= c_SAOK;
        end else begin
            r_state <= w_nextState;
            if ((r_state == RUN) && w_excW) begin
                r_cpuStat <= W_stat;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if ((r_state == RUN) && w_excW) begin
            w_nextState = HALTED;
        end
    end

    always_comb begin
        F_stall  = w_fStallRun;
        D_stall  = w_dataHaz;
        W_stall  = w_excW;
        D_bubble = w_dBubbleRun;
        E_bubble = w_eBubbleRun;
        M_bubble = w_excM || w_excW;
        set_cc   = (E_icode == ICODE_W'(c_IOPQ)) && !w_excM && !w_excW;
        if (r_state == HALTED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
            E_bubble = 1'b1;
            D_bubble = 1'b0;
            set_cc   = 1'b0;
        end
    end

    assign halted   = (r_state == HALTED);
    assign cpu_stat = r_cpuStat;

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   ((r_state == RUN) && w_fStallRun),
        .o_count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubbleCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   ((r_state == RUN) && (w_dBubbleRun || w_eBubbleRun)),
        .o_count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispredCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   ((r_state == RUN) && w_mispred),
        .o_count (mispred_cnt)
    );

endmodule

`default_nettype wire

// File: doc/y86_pipe_ctrl.md
Name: y86_pipe_ctrl

Overview:
- Hazard and pipeline-control unit for the five-stage Y86-64 pipeline (F/D/E/M/W).
- Generates stall/bubble controls for every pipe_reg stage and the condition-code write enable.
- Tracks processor run state and latches the final status.
- Keeps saturating performance counters.
- Parametrised successor to the fixed hazard logic: configurable field widths, a selectable forwarding/no-forwarding mode, and registered halt/status and statistics behaviour.

Parameters:
- ICODE_W, 4, icode field width
- REG_W, 4, register-ID width; all-ones means RNONE
- CNT_W, 32, width of each performance counter
- FWD_EN, 1, 1 = forwarding datapath present (load/use stall only); 0 = stall on every RAW hazard

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- D_icode  in  ICODE_W  icode in D register
- E_icode  in  ICODE_W  icode in E register
- M_icode  in  ICODE_W  icode in M register
- d_srcA  in  REG_W  decode source A
- d_srcB  in  REG_W  decode source B
- E_dstE  in  REG_W  E-stage destination E
- E_dstM  in  REG_W  E-stage destination M
- M_dstE  in  REG_W  M-stage destination E
- M_dstM  in  REG_W  M-stage destination M
- W_dstE  in  REG_W  W-stage destination E
- W_dstM  in  REG_W  W-stage destination M
- e_Cnd  in  1  branch condition from execute
- m_stat  in  2  status leaving memory stage
- W_stat  in  2  status in W register
- F_stall, D_stall, W_stall  out  1  hold stage register
- D_bubble, E_bubble, M_bubble  out  1  insert nop into stage register
- set_cc  out  1  condition-code write enable
- halted  out  1  processor stopped
- cpu_stat  out  2  latched final status
- stall_cnt, bubble_cnt, mispred_cnt  out  CNT_W  performance counters

Behaviour:
- Constants:
  - icodes: HALT=0, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B, MRMOVQ=5.
  - stat: AOK=0, HLT=1, ADR=2, INS=3.
  - "exc(s)" means s != AOK.
- Control outputs are combinational from current inputs and state (zero latency).
- load_use = E_icode∈{MRMOVQ,POPQ} && E_dstM!=RNONE && E_dstM∈{d_srcA,d_srcB}.
- raw (FWD_EN=0 only): any of E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM != RNONE and equal to a non-RNONE d_srcA/d_srcB. When FWD_EN=1, raw is 0.
- data_haz = load_use | raw.
- ret_haz = RET∈{D_icode,E_icode,M_icode}.
- mispred = E_icode==JXX && !e_Cnd.
- Stage controls:
  - F_stall = data_haz | ret_haz
  - D_stall = data_haz
  - D_bubble = mispred | (ret_haz & !data_haz)
  - E_bubble = mispred | data_haz
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_icode==OPQ & !exc(m_stat) & !exc(W_stat)
- Never assert stall and bubble together on one stage; D_stall has priority (load_use with ret ⇒ stall D, no D bubble).
- FSM states: RUN, HALTED.
  - RUN → HALTED on a clock edge where exc(W_stat); cpu_stat <= W_stat on that edge.
  - HALTED is absorbing until rst.
- In HALTED, these are forced to 1: F_stall, D_stall, W_stall, M_bubble, E_bubble. These are forced to 0: D_bubble, set_cc.
- halted = (state==HALTED), registered.
- Counters increment only in RUN, each saturating at all-ones:
  - stall_cnt +1 when F_stall
  - bubble_cnt +1 when D_bubble|E_bubble
  - mispred_cnt +1 when mispred
- rst (any state, mid-operation): state=RUN, halted=0, cpu_stat=AOK, all counters=0. Combinational outputs then follow inputs from the next cycle.

Decomposition:
- Package y86_pkg holds:
  - icode localparams
  - stat encodings (AOK/HLT/ADR/INS)
  - RNONE
  - state enum {RUN,HALTED}
- Sub-module sat_counter #(W): increments on inc, sync clear on rst, saturates at all-ones. Instantiated three times.

Test Plan:
- Load/use, FWD_EN=1: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
- RAW without forwarding, FWD_EN=0: M_dstE=2, d_srcB=2, E not load → F_stall=D_stall=E_bubble=1. Same stimulus with FWD_EN=1 → all 0.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0; mispred_cnt +1.
- Ret plus load/use: D_icode=9 and load_use active → D_stall=1, D_bubble=0. Next cycle, load_use cleared → D_bubble=1, F_stall=1.
- Halt: m_stat=ADR → M_bubble=1, set_cc=0 with E_icode=6. Then W_stat=ADR at edge → halted=1, cpu_stat=2, counters frozen. rst pulse → halted=0, counters=0.
- Saturation: CNT_W=3, hold F_stall for 10 cycles → stall_cnt=7.
